// File: rtl/hs4_rx_pkg.sv
// hs4_rx shared definitions
// data width default and FSM encodings
package hs4_rx_pkg;

    localparam int DEF_DATA_MSB = 7;

    typedef enum logic {
        IDLE = 1'b0,
        ACKH = 1'b1
    } state_t;

endpackage

// File: rtl/hs4_rx_sync2ff.sv
// hs4_rx request synchronizer
// two-flop 1-bit synchronizer, async active-low reset
module sync2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // shift raw input through two flops into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hs4_rx.sv
// hs4_rx 4-phase bundled-data receiver
// sync req, capture into 2-entry FIFO, valid/ready out
module hs4_rx
    import hs4_rx_pkg::*;
#(
    parameter int DATA_MSB = DEF_DATA_MSB
) (
    input  logic            clk_rx,
    input  logic            reset,
    input  logic            req,
    input  logic [DATA_MSB:0] indata,
    output logic            ack,
    output logic            vo,
    output logic [DATA_MSB:0] rdata,
    input  logic            rdy,
    output logic [7:0]      cnt,
    output logic            err
);

    logic            req_s;
    state_t          state;
    state_t          state_nx;
    logic [DATA_MSB:0] mem [2];
    logic            wptr;
    logic            rptr;
    logic [1:0]      occ;
    logic            full;
    logic            push;
    logic            pop;
    logic            pend;

    sync2ff u_sync (
        .clk   (clk_rx),
        .rst_n (reset),
        .d     (req),
        .q     (req_s)
    );

    assign full  = (occ == 2'd2);
    assign vo    = (occ != 2'd0);
    assign pop   = vo & rdy;
    assign rdata = mem[rptr];
    assign ack   = (state == ACKH);

    // handshake state register
    always_ff @(posedge clk_rx or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // capture when a slot is free or being freed this edge
    always_comb begin
        state_nx = state;
        push     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_s && (!full || pop)) begin
                    push     = 1'b1;
                    state_nx = ACKH;
                end
            end
            ACKH: begin
                if (!req_s) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk_rx or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wptr] <= indata;
                wptr      <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            occ <= occ + 2'(push) - 2'(pop);
        end
    end

    // capture counter, wraps naturally
    always_ff @(posedge clk_rx or negedge reset) begin
        if (!reset) begin
            cnt <= 8'd0;
        end else if (push) begin
            cnt <= cnt + 8'd1;
        end
    end

    // flag a request withdrawn while stalled
    always_ff @(posedge clk_rx or negedge reset) begin
        if (!reset) begin
            pend <= 1'b0;
            err  <= 1'b0;
        end else if (state == IDLE) begin
            if (push) begin
                pend <= 1'b0;
            end else if (req_s) begin
                pend <= 1'b1;
            end else if (pend) begin
                pend <= 1'b0;
                err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hs4_rx.sv
// hs4_rx testbench
// directed handshakes with scoreboard on the output side
module tb_hs4_rx;

    logic       clk_rx;
    logic       reset;
    logic       req;
    logic [7:0] indata;
    logic       ack;
    logic       vo;
    logic [7:0] rdata;
    logic       rdy;
    logic [7:0] cnt;
    logic       err;

    int n_cmp;
    int n_bad;
    logic [7:0] sb [$];
    logic [7:0] exp_cnt;

    hs4_rx dut (
        .clk_rx (clk_rx),
        .reset  (reset),
        .req    (req),
        .indata (indata),
        .ack    (ack),
        .vo     (vo),
        .rdata  (rdata),
        .rdy    (rdy),
        .cnt    (cnt),
        .err    (err)
    );

    initial clk_rx = 1'b0;
    always #5 clk_rx = ~clk_rx;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: a pop happens on the next edge when vo&rdy
    always @(negedge clk_rx) begin
        if (reset && vo === 1'b1 && rdy === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {24'd0, rdata}, 32'hFFFF_FFFF);
            end else begin
                chk("rdata_order", {24'd0, rdata}, {24'd0, sb.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk_rx);
        #1;
    endtask

    task automatic wait_ack(input logic v);
        int n;
        n = 0;
        while (ack !== v && n < 20) begin
            tick();
            n++;
        end
        chk("ack_wait", {31'd0, ack}, {31'd0, v});
    endtask

    task automatic send(input logic [7:0] d);
        indata = d;
        req = 1'b1;
        sb.push_back(d);
        exp_cnt++;
        wait_ack(1'b1);
        req = 1'b0;
        wait_ack(1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        sb.delete();
        exp_cnt = 8'd0;
        #1;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_vo", {31'd0, vo}, 32'd0);
        chk("rst_cnt", {24'd0, cnt}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_cnt = 8'd0;
        req = 1'b0;
        rdy = 1'b0;
        indata = 8'h00;
        reset = 1'b1;
        #2;
        do_reset();
        chk("rst_rdata", {24'd0, rdata}, 32'd0);

        // single transfer with latency checks
        tick();
        rdy = 1'b1;
        indata = 8'hA5;
        req = 1'b1;
        sb.push_back(8'hA5);
        exp_cnt++;
        tick();
        chk("lat_r1", {31'd0, ack}, 32'd0);
        tick();
        chk("lat_r2", {31'd0, ack}, 32'd0);
        tick();
        chk("lat_r3", {31'd0, ack}, 32'd1);
        chk("single_vo", {31'd0, vo}, 32'd1);
        chk("single_rdata", {24'd0, rdata}, 32'hA5);
        chk("single_cnt", {24'd0, cnt}, {24'd0, exp_cnt});
        req = 1'b0;
        tick();
        chk("lat_f1", {31'd0, ack}, 32'd1);
        tick();
        chk("lat_f2", {31'd0, ack}, 32'd1);
        tick();
        chk("lat_f3", {31'd0, ack}, 32'd0);

        // backpressure: third request stalls
        rdy = 1'b0;
        send(8'h11);
        send(8'h22);
        indata = 8'h33;
        req = 1'b1;
        sb.push_back(8'h33);
        repeat (6) tick();
        chk("stall_ack", {31'd0, ack}, 32'd0);
        chk("stall_cnt", {24'd0, cnt}, {24'd0, exp_cnt});
        chk("stall_head", {24'd0, rdata}, 32'h11);
        exp_cnt++;
        rdy = 1'b1;
        wait_ack(1'b1);
        req = 1'b0;
        wait_ack(1'b0);
        repeat (3) tick();
        chk("bp_cnt", {24'd0, cnt}, {24'd0, exp_cnt});
        chk("bp_drain", sb.size(), 32'd0);

        // full, pop on the edge the request is synchronized
        rdy = 1'b0;
        send(8'h44);
        send(8'h55);
        indata = 8'h66;
        req = 1'b1;
        sb.push_back(8'h66);
        exp_cnt++;
        tick();
        tick();
        chk("simul_pre", {31'd0, ack}, 32'd0);
        rdy = 1'b1;
        tick();
        chk("simul_ack", {31'd0, ack}, 32'd1);
        chk("simul_vo", {31'd0, vo}, 32'd1);
        chk("simul_head", {24'd0, rdata}, 32'h55);
        req = 1'b0;
        wait_ack(1'b0);
        repeat (3) tick();
        chk("simul_drain", sb.size(), 32'd0);

        // reset in the middle of a handshake
        rdy = 1'b0;
        indata = 8'h77;
        req = 1'b1;
        wait_ack(1'b1);
        chk("mid_vo", {31'd0, vo}, 32'd1);
        do_reset();
        sb.push_back(8'h77);
        exp_cnt++;
        wait_ack(1'b1);
        chk("mid_cnt", {24'd0, cnt}, {24'd0, exp_cnt});
        rdy = 1'b1;
        req = 1'b0;
        wait_ack(1'b0);
        repeat (2) tick();
        chk("mid_drain", sb.size(), 32'd0);

        // withdrawn request while full
        rdy = 1'b0;
        send(8'h81);
        send(8'h82);
        indata = 8'h83;
        req = 1'b1;
        repeat (4) tick();
        req = 1'b0;
        repeat (4) tick();
        chk("viol_err", {31'd0, err}, 32'd1);
        chk("viol_cnt", {24'd0, cnt}, {24'd0, exp_cnt});
        chk("viol_ack", {31'd0, ack}, 32'd0);
        rdy = 1'b1;
        repeat (4) tick();
        chk("viol_sticky", {31'd0, err}, 32'd1);
        chk("viol_drain", sb.size(), 32'd0);
        do_reset();

        // 256 transfers wrap the counter
        rdy = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send(8'(i) ^ 8'h5A);
        end
        repeat (3) tick();
        chk("wrap_cnt", {24'd0, cnt}, 32'd0);
        chk("wrap_drain", sb.size(), 32'd0);
        chk("wrap_err", {31'd0, err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
